// File: rtl/accum_seq.sv
// accum_seq -- sequencer for the bit-serial predictor accumulator (MCAC).
//
// Per frame the accumulator is cleared for one word, then six zero-predictor
// partial products are summed (result latched as SEZI), then two pole-predictor
// partial products are added on top (result latched as SEI).
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high
//   start     one-cycle request to run one frame
//   busy      high while a frame is in progress
//   done      one-cycle completion pulse
//   term_sel  product source select: 0..5 zero terms, 6..7 pole terms
//   bit_idx   current serial bit position, 0 = LSB
//   m1_sel    carry-clear to accumulator
//   m2_sel    sum-force-zero to accumulator
//   sezi_en   SEZI latch strobe (rising edge latches)
//   sei_en    SEI latch strobe (rising edge latches)
//
// Build option: define ACCUM_SEQ_BACKTOBACK_EN to queue one start received
// while busy and run the next frame without an intervening IDLE cycle.
//
// WORD_BITS must match the accumulator's 16-stage loop; 16 is the only
// legal value.

module accum_seq #(
    parameter int WORD_BITS = 16,
    parameter int N_ZERO    = 6,
    parameter int N_POLE    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [2:0] term_sel,
    output logic [3:0] bit_idx,
    output logic       m1_sel,
    output logic       m2_sel,
    output logic       sezi_en,
    output logic       sei_en
);

    localparam logic [3:0] LAST_BIT   = 4'(WORD_BITS - 1);
    localparam logic [3:0] PRE_LAST   = 4'(WORD_BITS - 2);
    localparam logic [2:0] LAST_ZERO  = 3'(N_ZERO - 1);
    localparam logic [2:0] FIRST_POLE = 3'(N_ZERO);
    localparam logic [2:0] LAST_POLE  = 3'(N_ZERO + N_POLE - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, ZERO, POLE} state_t;

    state_t state;
    logic   rerun;   // start the next frame straight from the last bit

`ifdef ACCUM_SEQ_BACKTOBACK_EN
    logic pending;
    assign rerun = pending | start;
`else
    assign rerun = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            term_sel <= '0;
            bit_idx  <= '0;
            m1_sel   <= 1'b1;
            m2_sel   <= 1'b1;
`ifdef ACCUM_SEQ_BACKTOBACK_EN
            pending  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    bit_idx  <= '0;
                    term_sel <= '0;
                    m1_sel   <= 1'b1;
                    m2_sel   <= 1'b1;
                    busy     <= 1'b0;
                    if (start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
`ifdef ACCUM_SEQ_BACKTOBACK_EN
                        pending <= 1'b0;
`endif
                    end
                end

                CLEAR: begin
`ifdef ACCUM_SEQ_BACKTOBACK_EN
                    if (start) pending <= 1'b1;
`endif
                    if (bit_idx == LAST_BIT) begin
                        state    <= ZERO;
                        bit_idx  <= '0;
                        term_sel <= '0;
                        m1_sel   <= 1'b0;
                        m2_sel   <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end

                ZERO, POLE: begin
`ifdef ACCUM_SEQ_BACKTOBACK_EN
                    if (start) pending <= 1'b1;
`endif
                    if (bit_idx == LAST_BIT) begin
                        // Word boundary: carry-clear drops again, sum keeps accumulating.
                        bit_idx <= '0;
                        m1_sel  <= 1'b0;
                        if (state == ZERO && term_sel == LAST_ZERO) begin
                            state    <= POLE;
                            term_sel <= FIRST_POLE;
                        end else if (state == POLE && term_sel == LAST_POLE) begin
                            done     <= 1'b1;
                            term_sel <= '0;
                            m1_sel   <= 1'b1;
                            m2_sel   <= 1'b1;
                            if (rerun) begin
                                state <= CLEAR;
`ifdef ACCUM_SEQ_BACKTOBACK_EN
                                pending <= 1'b0;
`endif
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            term_sel <= term_sel + 3'd1;
                        end
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        // Registered output: raise carry-clear for the coming bit 15.
                        m1_sel  <= (bit_idx == PRE_LAST);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Strobes launch on the falling edge so their rising edge falls mid-cycle,
    // after the posedge that shifted in the final bit, while the loop is stable.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            sezi_en <= 1'b0;
            sei_en  <= 1'b0;
        end else begin
            sezi_en <= (state == POLE) && (term_sel == FIRST_POLE) && (bit_idx == '0);
            sei_en  <= done;
        end
    end

endmodule

// File: tb/tb_accum_seq.sv
// tb_accum_seq -- self-checking bench for accum_seq.
// A frame-position model predicts every output each cycle; a bit-serial
// accumulator driven by the DUT controls produces SEZI/SEI, which are compared
// against hand-computed sums.

module tb_accum_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic       busy, done, m1_sel, m2_sel, sezi_en, sei_en;
    logic [2:0] term_sel;
    logic [3:0] bit_idx;

`ifdef ACCUM_SEQ_BACKTOBACK_EN
    localparam bit BB = 1'b1;
`else
    localparam bit BB = 1'b0;
`endif

    accum_seq #(.WORD_BITS(16), .N_ZERO(6), .N_POLE(2)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .term_sel(term_sel), .bit_idx(bit_idx), .m1_sel(m1_sel), .m2_sel(m2_sel),
        .sezi_en(sezi_en), .sei_en(sei_en)
    );

    always #5 clk = ~clk;

    logic [12:0] outs;
    assign outs = {busy, done, term_sel, bit_idx, m1_sel, m2_sel, sezi_en, sei_en};
    localparam logic [12:0] RESET_OUTS = 13'h00C;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Bit-serial accumulator environment: LSB first, 16-bit circulating loop.
    logic [15:0] terms [8];
    logic [15:0] loop_w = '0;
    logic        carry = 1'b0;
    logic [14:0] sezi_q = '0, sei_q = '0;
    int          sezi_edges = 0, sei_edges = 0;

    always @(posedge clk) begin
        logic a, p, s;
        a = loop_w[0];
        p = terms[term_sel][bit_idx];
        s = m2_sel ? 1'b0 : (a ^ p ^ carry);
        carry  <= m1_sel ? 1'b0 : ((a & p) | (a & carry) | (p & carry));
        loop_w <= {s, loop_w[15:1]};
    end

    always @(posedge sezi_en) begin sezi_q <= loop_w[15:1]; sezi_edges++; end
    always @(posedge sei_en)  begin sei_q  <= loop_w[15:1]; sei_edges++;  end

    // Frame-position model: k = cycles since the start-sampling edge, -1 = idle.
    initial begin
        int k, prev_k;
        bit pend, done_e, done_prev, s, r;
        logic [12:0] exp_o;
        int w, b;
        k = -1; pend = 0; done_e = 0; done_prev = 0;
        forever begin
            @(posedge clk);
            s = start; r = reset;
            if (r) begin
                k = -1; pend = 0; done_e = 0; done_prev = 0;
            end else begin
                prev_k = k;
                done_prev = done_e;
                done_e = 0;
                if (prev_k < 0) begin
                    if (s) k = 0;
                end else if (prev_k < 143) begin
                    k = prev_k + 1;
                    if (s && BB) pend = 1;
                end else begin
                    done_e = 1;
                    if (BB && (pend || s)) begin k = 0; pend = 0; end
                    else k = -1;
                end
            end
            #1;
            if (k < 0) begin
                exp_o = {1'b0, done_e, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, done_prev};
            end else begin
                w = k / 16; b = k % 16;
                exp_o = {1'b1, done_e, (w == 0) ? 3'd0 : 3'(w - 1), 4'(b),
                         (w == 0) || (b == 15), (w == 0), (k == 113), done_prev};
            end
            check("outputs", {19'd0, outs}, {19'd0, exp_o});
        end
    end

    task automatic set_terms(input logic [15:0] z, input logic [15:0] p);
        for (int unsigned i = 0; i < 8; i++) terms[i] = (i < 6) ? z : p;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 300) begin @(posedge clk); #1; cnt++; end
    endtask

    task automatic run_frame(input logic [15:0] z, input logic [15:0] p,
                             input logic [14:0] exp_sezi, input logic [14:0] exp_sei);
        int cnt;
        set_terms(z, p);
        pulse_start();
        check("busy_rise", {31'd0, busy}, 32'd1);
        wait_done(cnt);
        check("latency", cnt, 32'd144);
        repeat (2) @(posedge clk);
        #1;
        check("sezi", {17'd0, sezi_q}, {17'd0, exp_sezi});
        check("sei", {17'd0, sei_q}, {17'd0, exp_sei});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt, cnt2, busy_low, se, si;
        logic [14:0] keep_sezi, keep_sei;
        set_terms('0, '0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {19'd0, outs}, {19'd0, RESET_OUTS});
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(16'h0001, 16'h0002, 15'h0003, 15'h0005);
        run_frame(16'hFFFF, 16'h0000, 15'h7FFD, 15'h7FFD);
        run_frame(16'h7FFF, 16'h0003, 15'h7FFD, 15'h0000);

        // Abort a frame with reset at cycle 70.
        set_terms(16'h1234, 16'h4321);
        se = sezi_edges; si = sei_edges;
        keep_sezi = sezi_q; keep_sei = sei_q;
        pulse_start();
        repeat (70) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1 check("abort_outputs", {19'd0, outs}, {19'd0, RESET_OUTS});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (160) @(posedge clk);
        #1;
        check("abort_no_strobe", sezi_edges + sei_edges, se + si);
        check("abort_keep", {2'd0, sezi_q, sei_q}, {2'd0, keep_sezi, keep_sei});
        @(negedge clk);
        run_frame(16'h0010, 16'h0100, 15'h0030, 15'h0130);

        // start coincident with reset: reset wins.
        @(negedge clk); reset = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("start_under_reset", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Second start at cycle 100 of a frame.
        set_terms(16'h0001, 16'h0002);
        pulse_start();
        repeat (100) @(posedge clk);
        pulse_start();
        wait_done(cnt);
        check("first_done", cnt, 32'd43);
        busy_low = 0; cnt2 = 0;
        do begin
            @(posedge clk); #1; cnt2++;
            if (busy !== 1'b1) busy_low++;
        end while (done !== 1'b1 && cnt2 < 200);
        if (BB) begin
            check("second_done_gap", cnt2, 32'd144);
            check("busy_never_drops", busy_low, 32'd0);
            repeat (2) @(posedge clk);
            #1 check("b2b_sei", {17'd0, sei_q}, 32'd5);
        end else begin
            check("single_done", cnt2, 32'd200);
            check("busy_dropped", busy_low, 32'd200);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/accum_seq.md
Name: accum_seq

Overview:
- Sequencer for the bit-serial predictor accumulator in the MCAC datapath.
- Per frame: clears the accumulator, then adds six zero-predictor partial products (word latched as SEZI), then two pole-predictor partial products (word latched as SEI).
- Drives the term-select mux and the bit index to the serial product generators, plus the accumulator's carry-clear, sum-clear and latch-enable controls.
- Sits between the frame controller (start/done) and the accumulator.

Parameters:
- WORD_BITS, 16, serial word length. Must equal the accumulator's 16-stage loop; 16 is the only legal value.
- N_ZERO, 6, zero-predictor terms per frame.
- N_POLE, 2, pole-predictor terms per frame.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- start  input  1  one-cycle request to run one frame
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle completion pulse
- term_sel  output  3  product source select: 0..5 zero terms, 6..7 pole terms
- bit_idx  output  4  current serial bit position, 0 = LSB
- m1_sel  output  1  carry-clear to accumulator
- m2_sel  output  1  sum-force-zero to accumulator
- sezi_en  output  1  SEZI latch strobe (rising edge latches)
- sei_en  output  1  SEI latch strobe (rising edge latches)

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. All outputs reset as follows.
  - state=IDLE, busy=0, done=0, term_sel=0, bit_idx=0.
  - m1_sel=1, m2_sel=1, sezi_en=0, sei_en=0.
- States: IDLE, CLEAR, ZERO, POLE.
- IDLE: m1_sel=1, m2_sel=1. A start sampled high → CLEAR, bit_idx=0, busy=1.
- CLEAR: one word (16 cycles), m1_sel=1, m2_sel=1. Flushes the loop and carry to zero. At bit_idx=15 → ZERO, term_sel=0.
- ZERO: m2_sel=0.
  - m1_sel=1 only when bit_idx=15, so no carry crosses into the next word.
  - At bit_idx=15: term_sel increments. After term N_ZERO-1 → POLE with term_sel=6.
- POLE: same m1_sel/m2_sel rules as ZERO. No clear between ZERO and POLE, so SEI = SEZI terms + pole terms.
  - After term 7, bit 15 → IDLE, busy=0, done=1 for one cycle.
- bit_idx: counts 0..15, wraps to 0 every word, and holds 0 in IDLE.
- Latch strobes:
  - sezi_en and sei_en come from falling-edge flops. Their rising edge lands half a cycle after the posedge that shifts in bit 15 of the final word, while the loop word is stable.
  - Each strobe is high for exactly one clk period.
  - sezi_en fires after zero term 5. It overlaps pole term 6 bit 0; no stall.
  - sei_en fires after pole term 7, in the same cycle as done.
- Latency: start sampled → done = 16 + 16·(N_ZERO+N_POLE) = 144 cycles.
- Arithmetic: two's complement, modulo 2^16. The accumulator exposes the word's upper 15 bits, so SEZI = word>>1.
- start while busy: ignored (see Optional Feature).
- Reset mid-frame: immediate return to IDLE with reset values. No strobe is emitted, and sezi/sei keep their reset contents.
- start coincident with reset: reset wins.

Optional Feature:
- Macro: ACCUM_SEQ_BACKTOBACK_EN.
- Defined:
  - A start seen while busy sets a pending flag; further starts while pending are dropped.
  - At frame end, done pulses and the FSM goes directly to CLEAR, with busy staying high and no IDLE cycle.
  - The pending flag clears on entry to CLEAR.
- Undefined:
  - start while busy is discarded.
  - At least one IDLE cycle separates frames.

Test Plan:
- Reset, then start: busy rises next cycle; done pulses exactly 144 cycles after start; term_sel steps 0..7 every 16 cycles; m1_sel high only at bit 15 in ZERO/POLE.
- Zero terms 0x0001 each, pole terms 0x0002: sezi = 3 (word 6), sei = 5 (word 10).
- Zero terms 0xFFFF each, pole terms 0x0000: sezi = 0x7FFD, sei = 0x7FFD.
- Zero terms 0x7FFF each, pole terms 0x0003:
  - zero word wraps to 0xFFFA, so sezi = 0x7FFD;
  - sei word = 0x0000, so sei = 0x0000.
- Assert reset at cycle 70 of a frame: all outputs return to reset values; no sezi_en/sei_en edge; a new start gives correct sums with no residue from the aborted frame.
- start pulsed at cycle 100 of a frame:
  - without the macro: ignored, one done;
  - with ACCUM_SEQ_BACKTOBACK_EN: second done exactly 144 cycles after the first, busy never drops.
